// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of JK bits between NREQ requesters.
// Optional macro JK_PRIO0_EN: requester 0 gets absolute priority over the round-robin set.
module jk_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBITS = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NBITS-1:0]     j_out,
  output logic [NBITS-1:0]     k_out,
  output logic [NBITS-1:0]     q,
  output logic                 grant_valid,
  output logic [2:0]           grant_id,
  output logic                 idx_err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]       r_state, w_state_d;
  logic [2:0]       r_rr_ptr, w_rr_ptr_d;
  logic [2:0]       r_grant_id;
  logic             r_idx_err;
  logic [NBITS-1:0] r_q, r_j, r_k;

  logic             w_found;
  logic [2:0]       w_gid;
  logic [1:0]       w_op;
  logic [IDXW-1:0]  w_idx;
  logic             w_in_range;
  logic [NBITS-1:0] w_mask, w_j, w_k, w_q_d;

  // Two passes: indices at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
`ifdef JK_PRIO0_EN
    if (req_valid[0]) begin
      w_found = 1'b1;
    end
    for (int i = 1; i < NREQ; i++) begin
      if (!w_found && i >= int'(r_rr_ptr) && req_valid[i]) begin
        w_found = 1'b1;
        w_gid   = 3'(i);
      end
    end
    for (int i = 1; i < NREQ; i++) begin
      if (!w_found && i < int'(r_rr_ptr) && req_valid[i]) begin
        w_found = 1'b1;
        w_gid   = 3'(i);
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i >= int'(r_rr_ptr) && req_valid[i]) begin
        w_found = 1'b1;
        w_gid   = 3'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i < int'(r_rr_ptr) && req_valid[i]) begin
        w_found = 1'b1;
        w_gid   = 3'(i);
      end
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    w_op      = '0;
    w_idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n && w_found && (w_gid == 3'(i));
      if (w_gid == 3'(i)) begin
        w_op  = req_op[2*i +: 2];
        w_idx = req_idx[IDXW*i +: IDXW];
      end
    end
  end

  // An out-of-range index decodes to an empty mask, so J=K=0 and q holds.
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < NBITS; b++) begin
      w_mask[b] = (int'(w_idx) == b);
    end
    w_in_range = |w_mask;
    w_j        = w_mask & {NBITS{w_op[1]}};
    w_k        = w_mask & {NBITS{w_op[0]}};
    w_q_d      = (w_j & ~r_q) | (~w_k & r_q);
  end

  always_comb begin
    w_rr_ptr_d = r_rr_ptr;
`ifdef JK_PRIO0_EN
    if (w_found && w_gid != 3'd0) begin
      w_rr_ptr_d = (w_gid == 3'(NREQ - 1)) ? 3'd0 : w_gid + 3'd1;
    end
`else
    if (w_found) begin
      w_rr_ptr_d = (w_gid == 3'(NREQ - 1)) ? 3'd0 : w_gid + 3'd1;
    end
`endif
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    w_state_d = w_found ? ISSUE : IDLE;
      ISSUE:   w_state_d = w_found ? ISSUE : IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_idx_err  <= 1'b0;
      r_q        <= '0;
      r_j        <= '0;
      r_k        <= '0;
    end else begin
      r_state  <= w_state_d;
      r_rr_ptr <= w_rr_ptr_d;
      r_j      <= w_found ? w_j : '0;
      r_k      <= w_found ? w_k : '0;
      if (w_found) begin
        r_q        <= w_q_d;
        r_grant_id <= w_gid;
        if (!w_in_range) begin
          r_idx_err <= 1'b1;
        end
      end
    end
  end

  assign q           = r_q;
  assign j_out       = r_j;
  assign k_out       = r_k;
  assign grant_valid = (r_state == ISSUE);
  assign grant_id    = r_grant_id;
  assign idx_err     = r_idx_err;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (NBITS=6) with a grant scoreboard and a bank model.
module tb_jk_bank_arbiter;

  localparam int NREQ = 4;
  localparam int NB   = 6;
  localparam int IW   = 3;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_op;
  logic [IW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]   req_ready;
  logic [NB-1:0]     j_out, k_out, q;
  logic              grant_valid;
  logic [2:0]        grant_id;
  logic              idx_err;

  typedef struct {
    logic [2:0]    gid;
    logic [NB-1:0] j;
    logic [NB-1:0] k;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [NB-1:0] m_q;
  logic          m_err;
  int            total = 0;
  int            bad   = 0;

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NB), .IDXW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(req_ready), .j_out(j_out), .k_out(k_out), .q(q), .grant_valid(grant_valid),
    .grant_id(grant_id), .idx_err(idx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [1:0] op, input int idx);
    req_valid[id]       = v;
    req_op[2*id +: 2]   = op;
    req_idx[IW*id +: IW] = 3'(idx);
  endtask

  task automatic expect_grant(input int id, input logic [1:0] op, input int idx);
    exp_t          e;
    logic [NB-1:0] one;
    one   = (idx < NB) ? (NB'(1) << idx) : '0;
    e.gid = 3'(id);
    e.j   = op[1] ? one : '0;
    e.k   = op[0] ? one : '0;
    e.err = (idx >= NB);
    sb.push_back(e);
  endtask

  task automatic cycle(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".gv"}, 32'(grant_valid), 32'd1);
      chk({tag, ".gid"}, 32'(grant_id), 32'(e.gid));
      chk({tag, ".j"}, 32'(j_out), 32'(e.j));
      chk({tag, ".k"}, 32'(k_out), 32'(e.k));
      m_q = (e.j & ~m_q) | (~e.k & m_q);
      if (e.err) m_err = 1'b1;
    end else begin
      chk({tag, ".gv0"}, 32'(grant_valid), 32'd0);
      chk({tag, ".j0"}, 32'(j_out), 32'd0);
      chk({tag, ".k0"}, 32'(k_out), 32'd0);
    end
    chk({tag, ".q"}, 32'(q), 32'(m_q));
    chk({tag, ".err"}, 32'(idx_err), 32'(m_err));
  endtask

  initial begin
    int id;
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_idx   = '0;
    m_q       = '0;
    m_err     = 1'b0;

    // Reset state, ready gated while in reset
    req_valid = 4'hF;
    #3;
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.q", 32'(q), 32'd0);
    chk("rst.gv", 32'(grant_valid), 32'd0);
    chk("rst.err", 32'(idx_err), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("idle");

    // Single requester: set then toggle the same bit
    set_req(2, 1'b1, OP_SET, 5);
    #1;
    chk("a.ready", 32'(req_ready), 32'h4);
    expect_grant(2, OP_SET, 5);
    cycle("a.set");
    chk("a.q20", 32'(q), 32'h20);
    set_req(2, 1'b1, OP_TGL, 5);
    expect_grant(2, OP_TGL, 5);
    cycle("a.tgl");
    chk("a.q00", 32'(q), 32'h00);
    set_req(2, 1'b0, OP_HOLD, 0);
    cycle("a.drop");

    // Load a pattern, then reset with a command in flight
    set_req(3, 1'b1, OP_SET, 0);
    expect_grant(3, OP_SET, 0);
    cycle("p.3");
    set_req(3, 1'b0, OP_HOLD, 0);
    set_req(0, 1'b1, OP_SET, 2);
    expect_grant(0, OP_SET, 2);
    cycle("p.0");
    set_req(0, 1'b0, OP_HOLD, 0);
    set_req(1, 1'b1, OP_SET, 5);
    expect_grant(1, OP_SET, 5);
    cycle("p.1");
    chk("p.q25", 32'(q), 32'h25);
    set_req(1, 1'b1, OP_SET, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr.q", 32'(q), 32'd0);
    chk("mr.j", 32'(j_out), 32'd0);
    chk("mr.k", 32'(k_out), 32'd0);
    chk("mr.gv", 32'(grant_valid), 32'd0);
    chk("mr.ready", 32'(req_ready), 32'd0);
    m_q = '0;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    chk("mr.hold_q", 32'(q), 32'd0);
    chk("mr.hold_gv", 32'(grant_valid), 32'd0);
    set_req(1, 1'b0, OP_HOLD, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesters, each setting its own index
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, OP_SET, i);
    #1;
    chk("b.ready", 32'(req_ready), 32'h1);
    for (int c = 0; c < 5; c++) begin
`ifdef JK_PRIO0_EN
      id = 0;
`else
      id = c % NREQ;
`endif
      expect_grant(id, OP_SET, id);
      cycle("b.rr");
    end
`ifdef JK_PRIO0_EN
    chk("b.q", 32'(q), 32'h01);
`else
    chk("b.q", 32'(q), 32'h0F);
`endif
    req_valid = '0;

    // Only 1 and 3 valid: alternate fairly across the wrap
    set_req(1, 1'b1, OP_RST, 1);
    set_req(3, 1'b1, OP_RST, 3);
    #1;
    chk("c.ready", 32'(req_ready), 32'h2);
    for (int c = 0; c < 6; c++) begin
      id = (c % 2 == 0) ? 1 : 3;
      expect_grant(id, OP_RST, id);
      cycle("c.wrap");
    end
`ifdef JK_PRIO0_EN
    chk("c.q", 32'(q), 32'h01);
`else
    chk("c.q", 32'(q), 32'h05);
`endif
    req_valid = '0;

    // Out-of-range index and hold op
    set_req(0, 1'b1, OP_SET, 7);
    expect_grant(0, OP_SET, 7);
    cycle("d.oor");
    set_req(0, 1'b1, OP_HOLD, 1);
    expect_grant(0, OP_HOLD, 1);
    cycle("d.hold");
    req_valid = '0;
    cycle("d.idle");
    chk("d.err_sticky", 32'(idx_err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("d.err_clr", 32'(idx_err), 32'd0);
    m_q = '0;
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Requesters 0,1,2 contend, then 0 drops out
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, OP_TGL, i);
    for (int c = 0; c < 3; c++) begin
`ifdef JK_PRIO0_EN
      id = 0;
`else
      id = c;
`endif
      expect_grant(id, OP_TGL, id);
      cycle("e.three");
    end
    set_req(0, 1'b0, OP_HOLD, 0);
    for (int c = 0; c < 3; c++) begin
      id = (c == 1) ? 2 : 1;
      expect_grant(id, OP_TGL, id);
      cycle("e.two");
    end
    req_valid = '0;
    cycle("e.idle");
`ifdef JK_PRIO0_EN
    chk("e.q", 32'(q), 32'h05);
`else
    chk("e.q", 32'(q), 32'h03);
`endif
    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares a bank of NBITS JK storage bits between NREQ requesters.
- Each requester issues a JK command (hold/reset/set/toggle) to one bit index.
- A round-robin arbiter accepts at most one command per cycle and drives the bank's J/K lines.
- The block keeps the bank state q with JK semantics: Q+ = J&~Q | ~K&Q.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NBITS, 8, number of JK bits in the bank.
- IDXW, 3, width of a bit index; must satisfy 2^IDXW >= NBITS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester command valid.
- req_op  input  2*NREQ  per-requester op, requester i at [2i+1:2i]: 00 hold, 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1).
- req_idx  input  IDXW*NREQ  per-requester target bit, requester i at [IDXW*i+IDXW-1:IDXW*i].
- req_ready  output  NREQ  one-hot (or zero) acceptance, combinational.
- j_out  output  NBITS  registered J pulse of the last accepted command.
- k_out  output  NBITS  registered K pulse of the last accepted command.
- q  output  NBITS  bank state.
- grant_valid  output  1  registered: a command was accepted on the previous edge.
- grant_id  output  3  registered: index of that requester.
- idx_err  output  1  sticky flag: an out-of-range index was accepted.

Behaviour:
- Reset (rst_n=0, asynchronous): the following all go to 0 immediately and stay 0 while rst_n=0: q, j_out, k_out, grant_valid, grant_id, idx_err, rr_ptr, state.
- req_ready is 0 while rst_n=0.
- Arbitration is combinational, round-robin:
  - Search starts at rr_ptr and wraps modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - With no valid requests, req_ready is all-zero.
- Handshake:
  - A command is accepted at the edge where req_valid[i] & req_ready[i].
  - A requester keeps op and idx stable while valid is high and unaccepted.
  - A requester may drop valid before acceptance; nothing happens in that case.
- On acceptance at edge t:
  - rr_ptr <= (i+1) mod NREQ.
  - q[idx] updates per the JK equation at edge t; other bits are unchanged.
  - j_out/k_out hold only bit idx set per op, for exactly one cycle after t.
  - grant_valid=1 and grant_id=i for the cycle after t.
- With no acceptance, the next edge clears j_out, k_out and grant_valid, and leaves rr_ptr unchanged.
- Hold op (00): accepted and granted; q is unchanged; j_out/k_out stay all-zero.
- idx >= NBITS: accepted and granted; q, j_out and k_out are unchanged; idx_err <= 1 until reset.
- Throughput and latency:
  - One command per cycle sustained; back-to-back grants have no bubble.
  - q is visible 0 cycles after the accept edge.
  - Consecutive commands to the same bit apply in grant order. Example: set then toggle gives q=0.
- FSM state (IDLE/ISSUE) mirrors grant_valid:
  - IDLE -> ISSUE on acceptance.
  - ISSUE -> ISSUE on another acceptance.
  - ISSUE -> IDLE when no acceptance.
- Reset asserted mid-stream: an in-flight grant is discarded; the bank clears with no partial update.
  - The first edge after rst_n rises arbitrates from requester 0.

Optional Feature:
- Macro JK_PRIO0_EN.
- Defined: requester 0 has absolute priority. If req_valid[0]=1 it is granted regardless of rr_ptr, and rr_ptr is not advanced by a requester-0 grant. Requesters 1..NREQ-1 round-robin among themselves when requester 0 is idle.
- Undefined: pure round-robin over all NREQ requesters as above.

Test Plan:
- Reset check: rst_n=0 mid-cycle with q=8'hA5 -> q, j_out, k_out, grant_valid, idx_err =0 immediately, req_ready=0.
- Single command: requester 2 set idx 5, then toggle idx 5 -> q=8'h20 after the first edge; j_out=8'h20, k_out=0 for one cycle; q=8'h00 after the second edge; grant_id=2 both times.
- Round-robin: all 4 valid, each set idx=i, held 4 cycles -> grant order 0,1,2,3, one per cycle; q=8'h0F; then with all still valid, grant order continues 0,1,...
- Fairness/wrap: only requesters 1 and 3 valid continuously for 6 cycles -> grants 1,3,1,3,1,3.
- Boundary: NBITS=6, requester 0 sets idx 7 -> accepted, grant_valid=1, q unchanged, idx_err=1 until reset; a hold op -> granted, j_out=k_out=0.
- Feature JK_PRIO0_EN: requesters 0,1,2 valid for 3 cycles -> grants 0,0,0. Then 0 drops -> grants 1,2,1; without the macro -> grants 0,1,2.
